// File: rtl/sb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sb_arbiter_pkg
// Shared definitions for the two-master system-bus arbiter in front of dmem:
//   - sl_mask_e   : access size codes carried on the byte_mask lines
//   - sb_state_e  : sequencer states (IDLE -> RD -> CAP -> WR)
//   - write-strobe and grant encodings
//   - req_valid() : a request counts only if it asks for a real access size
//   - lane_enables(): byte enables of a store for a given size and lane
// -----------------------------------------------------------------------------
package sb_arbiter_pkg;

    typedef enum logic [1:0] {
        SL_NONE = 2'b00,
        SL_B    = 2'b01,
        SL_H    = 2'b10,
        SL_W    = 2'b11
    } sl_mask_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_CAP  = 2'b10,
        ST_WR   = 2'b11
    } sb_state_e;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam logic GRANT_M0 = 1'b0;
    localparam logic GRANT_M1 = 1'b1;

    // dmem is one 32-bit word of four byte lanes
    localparam int LANES = 4;

    // A request with size SL_NONE is treated as no request at all.
    function automatic logic req_valid(input logic re, input logic we,
                                       input logic [1:0] mask);
        return (re | we) && (mask != SL_NONE);
    endfunction

    // Byte enables for a store. Half-word lane is chosen by lane[1] only;
    // a misaligned lane[0] is silently ignored.
    function automatic logic [3:0] lane_enables(input sl_mask_e mask,
                                                input logic [1:0] lane);
        logic [3:0] be;
        case (mask)
            SL_B:    be = 4'b0001 << lane;
            SL_H:    be = lane[1] ? 4'b1100 : 4'b0011;
            SL_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/sb_arbiter_if.sv
// -----------------------------------------------------------------------------
// sb_arbiter_if
// One master's port onto the system-bus arbiter.
//   un_sign   : 1 = zero-extend loads, 0 = sign-extend
//   byte_mask : access size (sl_mask_e codes)
//   re / we   : read / write request, held until ready; we wins over re
//   addr      : byte address
//   wdata     : right-aligned store data
//   rdata     : extended load data, holds until this master's next read
//   ready     : one-cycle completion pulse
// modport master : the requesting side (core / debug / DMA)
// modport slave  : the arbiter side
// -----------------------------------------------------------------------------
interface sb_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          un_sign;
    logic [1:0]    byte_mask;
    logic          re;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ready;

    modport master (
        output un_sign, byte_mask, re, we, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  un_sign, byte_mask, re, we, addr, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/sb_arbiter_lane_unit.sv
// -----------------------------------------------------------------------------
// sb_arbiter_lane_unit  (purely combinational)
// Load path : pick the byte/half/word addressed by lane out of a dmem word and
//             sign- or zero-extend it.
// Store path: merge right-aligned store data into the lanes selected by
//             lane/mask, keeping the other lanes of the word read from dmem.
// Ports
//   lane      in  2   addr[1:0] of the access
//   mask      in  2   access size
//   un_sign   in  1   1 = zero-extend, 0 = sign-extend
//   rword     in  32  word read from dmem
//   wdata     in  32  right-aligned store data
//   load_data out 32  extended load result
//   merged    out 32  rword with the store lanes replaced
// -----------------------------------------------------------------------------
module sb_arbiter_lane_unit
    import sb_arbiter_pkg::*;
(
    input  logic [1:0]  lane,
    input  sl_mask_e    mask,
    input  logic        un_sign,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [3:0]  be;
    logic [31:0] wrep;

    always_comb begin
        sel_byte = 8'h00;
        case (lane)
            2'd0:    sel_byte = rword[7:0];
            2'd1:    sel_byte = rword[15:8];
            2'd2:    sel_byte = rword[23:16];
            default: sel_byte = rword[31:24];
        endcase
        sel_half = lane[1] ? rword[31:16] : rword[15:0];
    end

    always_comb begin
        load_data = '0;
        case (mask)
            SL_B:    load_data = {{24{~un_sign & sel_byte[7]}}, sel_byte};
            SL_H:    load_data = {{16{~un_sign & sel_half[15]}}, sel_half};
            SL_W:    load_data = rword;
            default: load_data = '0;
        endcase
    end

    // Replicate the store data across the word so every lane sees its bits
    // at the correct position; the byte enables decide which lanes take it.
    always_comb begin
        be   = lane_enables(mask, lane);
        wrep = wdata;
        case (mask)
            SL_B:    wrep = {4{wdata[7:0]}};
            SL_H:    wrep = {2{wdata[15:0]}};
            default: wrep = wdata;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign merged[8*gi +: 8] = be[gi] ? wrep[8*gi +: 8] : rword[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/sb_arbiter.sv
// -----------------------------------------------------------------------------
// sb_arbiter
// Two-master arbiter/sequencer for the single word-wide dmem port.
// m0 is the core load/store path, m1 a second master (debug/DMA). Grants are
// round-robin on ties; byte/half stores become read-modify-write because dmem
// only has rw/addr/wdata for whole words. One access is in flight at a time.
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   m0, m1       master ports (sb_arbiter_if.slave)
//   s_rdata      dmem read data, valid one cycle after a read address
//   s_rw_o       1 = write s_wdata_o at s_addr_o this cycle
//   s_addr_o     word-aligned dmem address (zero outside RD/WR)
//   s_wdata_o    full-word write data (zero outside WR)
// Latency counted from the IDLE accept cycle (cycle 0):
//   full-word write ready at 1, read at 2, byte/half write at 3.
// -----------------------------------------------------------------------------
module sb_arbiter
    import sb_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
)(
    input  logic          clk,
    input  logic          rst,
    sb_arbiter_if.slave   m0,
    sb_arbiter_if.slave   m1,
    input  logic [DW-1:0] s_rdata,
    output logic          s_rw_o,
    output logic [AW-1:0] s_addr_o,
    output logic [DW-1:0] s_wdata_o
);

    sb_state_e     state_reg, state_next;
    logic          last_grant_reg;

    // Latched command: once accepted, the access completes even if the
    // master drops its request.
    logic          cmd_master_reg;
    logic          cmd_un_sign_reg;
    sl_mask_e      cmd_mask_reg;
    logic [AW-1:0] cmd_addr_reg;
    logic [DW-1:0] cmd_wdata_reg;
    logic          cmd_we_reg;

    // Word written in WR: store data for full writes, merged word otherwise
    logic [DW-1:0] wword_reg;
    logic [DW-1:0] rdata0_reg;
    logic [DW-1:0] rdata1_reg;

    logic          m0_valid, m1_valid;
    logic          pick_m1;
    logic          accept;
    logic          sel_un_sign;
    logic [1:0]    sel_mask;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic [DW-1:0] load_data;
    logic [DW-1:0] merged;
    logic [AW-1:0] word_addr;
    logic          done;
    logic          rd_done;

    // ---------------------------------------------------------------- arbitration
    always_comb begin
        m0_valid = req_valid(m0.re, m0.we, m0.byte_mask);
        m1_valid = req_valid(m1.re, m1.we, m1.byte_mask);
        // On a tie the master that was not granted last time wins.
        pick_m1  = m1_valid & (~m0_valid | (last_grant_reg == GRANT_M0));
        accept   = (state_reg == ST_IDLE) & (m0_valid | m1_valid);

        sel_un_sign = pick_m1 ? m1.un_sign   : m0.un_sign;
        sel_mask    = pick_m1 ? m1.byte_mask : m0.byte_mask;
        sel_we      = pick_m1 ? m1.we        : m0.we;
        sel_addr    = pick_m1 ? m1.addr      : m0.addr;
        sel_wdata   = pick_m1 ? m1.wdata     : m0.wdata;
    end

    sb_arbiter_lane_unit u_lane (
        .lane      (cmd_addr_reg[1:0]),
        .mask      (cmd_mask_reg),
        .un_sign   (cmd_un_sign_reg),
        .rword     (s_rdata),
        .wdata     (cmd_wdata_reg),
        .load_data (load_data),
        .merged    (merged)
    );

    assign word_addr = {cmd_addr_reg[AW-1:2], 2'b00};

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (sel_we && (sel_mask == SL_W)) ? ST_WR : ST_RD;
                end
            end
            ST_RD:   state_next = ST_CAP;
            ST_CAP:  state_next = cmd_we_reg ? ST_WR : ST_IDLE;
            ST_WR:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // Everything is forced low while rst is high so that an access aborted by
    // reset never issues its write or its ready pulse in the reset cycle.
    always_comb begin
        s_rw_o    = WRITE_DISABLE;
        s_addr_o  = '0;
        s_wdata_o = '0;
        done      = 1'b0;
        rd_done   = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_RD: begin
                    s_addr_o = word_addr;
                end
                ST_CAP: begin
                    rd_done = ~cmd_we_reg;
                    done    = ~cmd_we_reg;
                end
                ST_WR: begin
                    s_rw_o    = WRITE_ENABLE;
                    s_addr_o  = word_addr;
                    s_wdata_o = wword_reg;
                    done      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Load data is shown in the same cycle as the ready pulse (straight from
    // the lane unit) and held in the per-master register afterwards.
    always_comb begin
        m0.ready = done & (cmd_master_reg == GRANT_M0);
        m1.ready = done & (cmd_master_reg == GRANT_M1);
        m0.rdata = '0;
        m1.rdata = '0;
        if (!rst) begin
            m0.rdata = (rd_done && cmd_master_reg == GRANT_M0) ? load_data : rdata0_reg;
            m1.rdata = (rd_done && cmd_master_reg == GRANT_M1) ? load_data : rdata1_reg;
        end
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            last_grant_reg  <= GRANT_M1;
            cmd_master_reg  <= GRANT_M0;
            cmd_un_sign_reg <= 1'b0;
            cmd_mask_reg    <= SL_NONE;
            cmd_addr_reg    <= '0;
            cmd_wdata_reg   <= '0;
            cmd_we_reg      <= 1'b0;
            wword_reg       <= '0;
            rdata0_reg      <= '0;
            rdata1_reg      <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        last_grant_reg  <= pick_m1;
                        cmd_master_reg  <= pick_m1;
                        cmd_un_sign_reg <= sel_un_sign;
                        cmd_mask_reg    <= sl_mask_e'(sel_mask);
                        cmd_addr_reg    <= sel_addr;
                        cmd_wdata_reg   <= sel_wdata;
                        cmd_we_reg      <= sel_we;
                        wword_reg       <= sel_wdata;
                    end
                end
                ST_CAP: begin
                    if (cmd_we_reg) begin
                        wword_reg <= merged;
                    end else if (cmd_master_reg == GRANT_M0) begin
                        rdata0_reg <= load_data;
                    end else begin
                        rdata1_reg <= load_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sb_arbiter
// Directed bench for sb_arbiter with a small word-wide dmem model behind it.
// Each transaction drives one or both masters, watches a fixed window of
// cycles and records latency, data, and write activity for checking.
// -----------------------------------------------------------------------------
module tb_sb_arbiter;
    import sb_arbiter_pkg::*;

    typedef struct {
        logic        re;
        logic        we;
        logic [1:0]  mask;
        logic        us;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_rdata;
    logic        s_rw_o;
    logic [31:0] s_addr_o;
    logic [31:0] s_wdata_o;
    logic [31:0] mem [16];

    sb_arbiter_if #(.AW(32), .DW(32)) m0_if ();
    sb_arbiter_if #(.AW(32), .DW(32)) m1_if ();

    sb_arbiter #(.AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0        (m0_if),
        .m1        (m1_if),
        .s_rdata   (s_rdata),
        .s_rw_o    (s_rw_o),
        .s_addr_o  (s_addr_o),
        .s_wdata_o (s_wdata_o)
    );

    always #5 clk = ~clk;

    // dmem: synchronous write, one-cycle registered read
    always @(posedge clk) begin
        if (s_rw_o) mem[s_addr_o[5:2]] <= s_wdata_o;
        s_rdata <= mem[s_addr_o[5:2]];
    end

    int errors = 0;
    int checks = 0;

    int          r_lat0, r_lat1, r_rdy0, r_rdy1, r_wr_cnt, r_act;
    logic [31:0] r_data0, r_data1, r_wr_addr, r_wr_word;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic req_t mk(input logic re, input logic we, input logic [1:0] mask,
                                input logic us, input logic [31:0] addr,
                                input logic [31:0] wdata);
        req_t q;
        q.re = re; q.we = we; q.mask = mask; q.us = us; q.addr = addr; q.wdata = wdata;
        return q;
    endfunction

    task automatic clear_m0();
        m0_if.re = 1'b0; m0_if.we = 1'b0; m0_if.byte_mask = SL_NONE;
        m0_if.un_sign = 1'b0; m0_if.addr = '0; m0_if.wdata = '0;
    endtask

    task automatic clear_m1();
        m1_if.re = 1'b0; m1_if.we = 1'b0; m1_if.byte_mask = SL_NONE;
        m1_if.un_sign = 1'b0; m1_if.addr = '0; m1_if.wdata = '0;
    endtask

    // Drive both masters at a negedge, then observe 8 cycles at negedges.
    // A master's request is dropped as soon as its ready pulse is seen.
    task automatic run_pair(input string name, input req_t q0, input req_t q1);
        m0_if.re = q0.re; m0_if.we = q0.we; m0_if.byte_mask = q0.mask;
        m0_if.un_sign = q0.us; m0_if.addr = q0.addr; m0_if.wdata = q0.wdata;
        m1_if.re = q1.re; m1_if.we = q1.we; m1_if.byte_mask = q1.mask;
        m1_if.un_sign = q1.us; m1_if.addr = q1.addr; m1_if.wdata = q1.wdata;
        r_lat0 = 0; r_lat1 = 0; r_rdy0 = 0; r_rdy1 = 0; r_wr_cnt = 0; r_act = 0;
        r_data0 = '0; r_data1 = '0; r_wr_addr = '0; r_wr_word = '0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (s_rw_o) begin
                r_wr_cnt++;
                r_wr_addr = s_addr_o;
                r_wr_word = s_wdata_o;
            end
            if (s_rw_o || s_addr_o != 0) r_act++;
            if (m0_if.ready) begin
                r_rdy0++;
                if (r_lat0 == 0) begin r_lat0 = c; r_data0 = m0_if.rdata; end
                clear_m0();
            end
            if (m1_if.ready) begin
                r_rdy1++;
                if (r_lat1 == 0) begin r_lat1 = c; r_data1 = m1_if.rdata; end
                clear_m1();
            end
        end
        clear_m0();
        clear_m1();
        $display("%-10s m0 lat=%0d rdata=%08h | m1 lat=%0d rdata=%08h | writes=%0d last_wr=%08h@%08h",
                 name, r_lat0, r_data0, r_lat1, r_data1, r_wr_cnt, r_wr_word, r_wr_addr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_m0();
        clear_m1();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    req_t none_q;
    int   abort_wr, abort_rdy;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        none_q = mk(1'b0, 1'b0, SL_NONE, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        clear_m0();
        clear_m1();
        repeat (3) @(negedge clk);
        chk("rst_rw", {31'd0, s_rw_o}, 32'd0);
        chk("rst_ready", {30'd0, m1_if.ready, m0_if.ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_addr", s_addr_o, 32'h0);
        chk("idle_wdata", s_wdata_o, 32'h0);
        chk("idle_rdata0", m0_if.rdata, 32'h0);
        chk("idle_rdata1", m1_if.rdata, 32'h0);

        // full-word store: ready one cycle after accept
        run_pair("m0_sw", mk(1'b0, 1'b1, SL_W, 1'b0, 32'h10, 32'hDEADBEEF), none_q);
        chk("sw_lat", r_lat0, 1);
        chk("sw_wr_cnt", r_wr_cnt, 1);
        chk("sw_addr", r_wr_addr, 32'h10);
        chk("sw_word", r_wr_word, 32'hDEADBEEF);
        chk("sw_m1_rdy", r_rdy1, 0);

        // byte loads, top lane, both extensions
        run_pair("m0_lb_s", mk(1'b1, 1'b0, SL_B, 1'b0, 32'h13, 32'h0), none_q);
        chk("lb_s_lat", r_lat0, 2);
        chk("lb_s_data", r_data0, 32'hFFFFFFDE);
        chk("lb_s_hold", m0_if.rdata, 32'hFFFFFFDE);
        chk("lb_s_nowr", r_wr_cnt, 0);
        run_pair("m0_lb_u", mk(1'b1, 1'b0, SL_B, 1'b1, 32'h13, 32'h0), none_q);
        chk("lb_u_data", r_data0, 32'h000000DE);

        // half store into upper lane: read-modify-write; upper data bits ignored
        run_pair("m0_sh", mk(1'b0, 1'b1, SL_H, 1'b0, 32'h12, 32'hFFFF1234), none_q);
        chk("sh_lat", r_lat0, 3);
        chk("sh_wr_cnt", r_wr_cnt, 1);
        chk("sh_addr", r_wr_addr, 32'h10);
        chk("sh_word", r_wr_word, 32'h1234BEEF);

        run_pair("m0_lh_s", mk(1'b1, 1'b0, SL_H, 1'b0, 32'h10, 32'h0), none_q);
        chk("lh_s_data", r_data0, 32'hFFFFBEEF);
        run_pair("m0_lw", mk(1'b1, 1'b0, SL_W, 1'b0, 32'h11, 32'h0), none_q);
        chk("lw_data", r_data0, 32'h1234BEEF);

        // byte store into lane 1
        run_pair("m0_sb", mk(1'b0, 1'b1, SL_B, 1'b0, 32'h11, 32'h000000A5), none_q);
        chk("sb_lat", r_lat0, 3);
        chk("sb_word", r_wr_word, 32'h1234A5EF);

        // second master
        run_pair("m1_sw", none_q, mk(1'b0, 1'b1, SL_W, 1'b0, 32'h20, 32'h80007F01));
        chk("m1_sw_lat", r_lat1, 1);
        chk("m1_sw_addr", r_wr_addr, 32'h20);
        run_pair("m1_lh_s", none_q, mk(1'b1, 1'b0, SL_H, 1'b0, 32'h23, 32'h0));
        chk("m1_lh_s_data", r_data1, 32'hFFFF8000);
        chk("m1_lh_m0_rdy", r_rdy0, 0);
        run_pair("m1_lh_u", none_q, mk(1'b1, 1'b0, SL_H, 1'b1, 32'h22, 32'h0));
        chk("m1_lh_u_data", r_data1, 32'h00008000);
        chk("m0_rdata_hold", m0_if.rdata, 32'h1234BEEF);

        // SL_NONE on m0 is ignored; m1 served in the same cycle
        run_pair("none_m1lb", mk(1'b1, 1'b0, SL_NONE, 1'b0, 32'h10, 32'h0),
                 mk(1'b1, 1'b0, SL_B, 1'b0, 32'h21, 32'h0));
        chk("none_m1_lat", r_lat1, 2);
        chk("none_m1_data", r_data1, 32'h0000007F);
        chk("none_m0_rdy", r_rdy0, 0);
        chk("none_act", r_act, 1);

        // ties from reset: m0 first, then alternate
        do_reset();
        run_pair("tie1", mk(1'b1, 1'b0, SL_W, 1'b0, 32'h10, 32'h0),
                 mk(1'b1, 1'b0, SL_W, 1'b0, 32'h20, 32'h0));
        chk("tie1_m0_lat", r_lat0, 2);
        chk("tie1_m1_lat", r_lat1, 5);
        chk("tie1_m0_data", r_data0, 32'h1234A5EF);
        chk("tie1_m1_data", r_data1, 32'h80007F01);
        run_pair("tie2", mk(1'b1, 1'b0, SL_W, 1'b0, 32'h10, 32'h0),
                 mk(1'b1, 1'b0, SL_W, 1'b0, 32'h20, 32'h0));
        chk("tie2_m0_lat", r_lat0, 2);
        chk("tie2_m1_lat", r_lat1, 5);
        run_pair("m0_alone", mk(1'b1, 1'b0, SL_W, 1'b0, 32'h10, 32'h0), none_q);
        run_pair("tie3", mk(1'b1, 1'b0, SL_W, 1'b0, 32'h10, 32'h0),
                 mk(1'b1, 1'b0, SL_W, 1'b0, 32'h20, 32'h0));
        chk("tie3_m1_lat", r_lat1, 2);
        chk("tie3_m0_lat", r_lat0, 5);

        // reset during CAP of a byte store: no write, no ready
        @(negedge clk);
        m0_if.re = 1'b0; m0_if.we = 1'b1; m0_if.byte_mask = SL_B;
        m0_if.un_sign = 1'b0; m0_if.addr = 32'h10; m0_if.wdata = 32'h77;
        @(posedge clk);
        @(negedge clk);
        chk("abort_rd_addr", s_addr_o, 32'h10);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear_m0();
        #1;
        chk("abort_rw_now", {31'd0, s_rw_o}, 32'd0);
        chk("abort_rdy_now", {31'd0, m0_if.ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        abort_wr = 0;
        abort_rdy = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (s_rw_o) abort_wr++;
            if (m0_if.ready || m1_if.ready) abort_rdy++;
        end
        $display("abort      writes=%0d readies=%0d addr=%08h", abort_wr, abort_rdy, s_addr_o);
        chk("abort_wr", abort_wr, 0);
        chk("abort_rdy", abort_rdy, 0);
        chk("abort_addr", s_addr_o, 32'h0);
        chk("abort_rdata0", m0_if.rdata, 32'h0);
        run_pair("post_m1lw", none_q, mk(1'b1, 1'b0, SL_W, 1'b0, 32'h20, 32'h0));
        chk("post_m1_lat", r_lat1, 2);
        run_pair("post_m0lw", mk(1'b1, 1'b0, SL_W, 1'b0, 32'h10, 32'h0), none_q);
        chk("post_mem_kept", r_data0, 32'h1234A5EF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
